// File: rtl/pkt_wr_ctrl_if.sv
// Bundles the bus signals around pkt_wr_ctrl. Clock and reset stay plain
// ports on the module.
//   Avalon-ST sink  : st_data, st_valid, st_sop, st_eop, st_empty, st_ready
//   Avalon-MM write : address, writedata, write, waitrequest
//   Reader handoff  : rd_ctrl, rd_ctrl_rdy, pkt_begin, pkt_end, control
//   Status          : drop_cnt
// The master modport is the controller's view. The slave modport is the
// view of the environment (MAC, buffer memory and reader).
interface pkt_wr_ctrl_if;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic [1:0]  st_empty;
    logic        st_ready;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        write;
    logic        waitrequest;
    logic        rd_ctrl;
    logic        rd_ctrl_rdy;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] control;
    logic [15:0] drop_cnt;

    modport master (
        input  st_data, st_valid, st_sop, st_eop, st_empty, waitrequest, rd_ctrl_rdy,
        output st_ready, address, writedata, write, rd_ctrl, pkt_begin, pkt_end,
               control, drop_cnt
    );

    modport slave (
        output st_data, st_valid, st_sop, st_eop, st_empty, waitrequest, rd_ctrl_rdy,
        input  st_ready, address, writedata, write, rd_ctrl, pkt_begin, pkt_end,
               control, drop_cnt
    );
endinterface

// File: rtl/pkt_wr_ctrl.sv
// pkt_wr_ctrl: captures one Ethernet frame at a time from an Avalon-ST source.
// Each frame is written word by word into a packet buffer through an Avalon-MM
// write master. The buffered packet is then handed to rd_ctrl and held until
// rd_ctrl_rdy is seen. Frames that arrive during the hold are dropped and
// counted.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   bus   - pkt_wr_ctrl_if.master (stream sink, MM write master, reader
//           handoff, drop counter)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a sop beat; non-sop beats are discarded
// CAPTURE  | writing frame words; words beyond MAX_WORDS are discarded
// FLUSH    | stream stalled until the last buffer write has completed
// HANDOFF  | rd_ctrl held high; all incoming beats are discarded
module pkt_wr_ctrl #(
    parameter logic [31:0] BUF_BASE  = 32'h0000_0000,
    parameter int          MAX_WORDS = 512
) (
    input  logic          clk,
    input  logic          reset,
    pkt_wr_ctrl_if.master bus
);
    localparam int              CW        = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0]   MAX_CNT   = CW'(MAX_WORDS);
    localparam logic [15:0]     MAX_BYTES = 16'(MAX_WORDS * 4);

    if (MAX_WORDS < 1 || MAX_WORDS * 4 > 65535) begin : g_bad_max_words
        $error("pkt_wr_ctrl: MAX_WORDS must be in 1..16383");
    end

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_HANDOFF} state_t;

    state_t        state, state_nxt;
    logic          armed;
    logic          st_ready_c;
    logic          accept;
    logic          full;
    logic [CW-1:0] wcnt;
    logic          trunc;
    logic          err;
    logic [15:0]   len;
    logic [31:0]   wcnt_addr;
    logic [15:0]   wcnt_bytes;

    assign accept     = bus.st_valid && st_ready_c;
    assign full       = (wcnt == MAX_CNT);
    assign wcnt_addr  = BUF_BASE + 32'({wcnt, 2'b00});
    assign wcnt_bytes = 16'({wcnt, 2'b00});
    assign bus.st_ready = st_ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept && bus.st_sop) state_nxt = bus.st_eop ? S_FLUSH : S_CAPTURE;
            S_CAPTURE: if (accept && (bus.st_sop || bus.st_eop)) state_nxt = S_FLUSH;
            S_FLUSH:   if (!bus.write) state_nxt = S_HANDOFF;
            S_HANDOFF: if (bus.rd_ctrl_rdy) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The ready gate lets a new beat land on the same edge that a stalled
    // write retires. That edge reloads the write register, so the stream
    // keeps one word per cycle.
    always_comb begin
        st_ready_c = 1'b0;
        case (state)
            S_IDLE, S_CAPTURE: st_ready_c = armed && !(bus.write && bus.waitrequest);
            S_HANDOFF:         st_ready_c = 1'b1;
            default:           st_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed         <= 1'b0;
            bus.write     <= 1'b0;
            bus.address   <= BUF_BASE;
            bus.writedata <= 32'd0;
            bus.rd_ctrl   <= 1'b0;
            bus.pkt_begin <= BUF_BASE;
            bus.pkt_end   <= BUF_BASE;
            bus.control   <= 32'd0;
            bus.drop_cnt  <= 16'd0;
            wcnt          <= '0;
            trunc         <= 1'b0;
            err           <= 1'b0;
            len           <= 16'd0;
        end else begin
            armed <= 1'b1;
            if (bus.write && !bus.waitrequest) bus.write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && bus.st_sop) begin
                        bus.write     <= 1'b1;
                        bus.address   <= BUF_BASE;
                        bus.writedata <= bus.st_data;
                        wcnt          <= CW'(1);
                        trunc         <= 1'b0;
                        err           <= 1'b0;
                        len           <= 16'd4 - 16'(bus.st_empty);
                    end
                end
                S_CAPTURE: begin
                    if (accept) begin
                        if (bus.st_sop) begin
                            // A new frame started before eop. Close the
                            // current frame as an error and drop the new one.
                            err <= 1'b1;
                            len <= wcnt_bytes;
                            if (bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
                        end else begin
                            if (!full) begin
                                bus.write     <= 1'b1;
                                bus.address   <= wcnt_addr;
                                bus.writedata <= bus.st_data;
                                wcnt          <= wcnt + CW'(1);
                            end else begin
                                trunc <= 1'b1;
                            end
                            if (bus.st_eop) begin
                                if (trunc || full) len <= MAX_BYTES;
                                else               len <= wcnt_bytes + 16'd4 - 16'(bus.st_empty);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (!bus.write) begin
                        bus.pkt_begin <= BUF_BASE;
                        bus.pkt_end   <= wcnt_addr;
                        bus.control   <= {14'd0, err, trunc, len};
                        bus.rd_ctrl   <= 1'b1;
                    end
                end
                S_HANDOFF: begin
                    if (accept && bus.st_sop && bus.drop_cnt != 16'hFFFF)
                        bus.drop_cnt <= bus.drop_cnt + 16'd1;
                    if (bus.rd_ctrl_rdy) bus.rd_ctrl <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// Testbench for pkt_wr_ctrl with MAX_WORDS=8 and BUF_BASE=0.
module tb_pkt_wr_ctrl;
    logic clk;
    logic reset;
    pkt_wr_ctrl_if bus ();

    pkt_wr_ctrl #(.BUF_BASE(32'h0000_0000), .MAX_WORDS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          v;
        int          n;
        logic [1:0]  emp;
        int          stall_idx;
        int          stall_n;
        logic [31:0] exp_end;
        logic [31:0] exp_ctrl;
        int          exp_wr;
        int          exp_span;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] mem[16];
    int          wr_count;
    int          cyc = 0;
    int          first_cyc;
    int          last_cyc;
    int          cur_v;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic [31:0] stall_data;
    int          stall_left = 0;

    function automatic logic [31:0] fdata(int v, int i);
        return 32'h0A0B_0C0D + 32'(v) * 32'h0100_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory slave: waitrequest is driven after each falling edge, so it is
    // stable for the following rising edge.
    always @(negedge clk) begin
        if (bus.write && bus.address == stall_addr && stall_left > 0) begin
            bus.waitrequest = 1'b1;
            stall_left--;
        end else begin
            bus.waitrequest = 1'b0;
        end
    end

    // Write monitor. It sees the values that the next rising edge will use.
    always begin
        @(negedge clk);
        #2;
        if (bus.write && !bus.waitrequest) begin
            if (bus.address[31:2] < 16) begin
                mem[bus.address[5:2]] = bus.writedata;
            end else begin
                total++;
                bad++;
                $display("FAIL wr_addr_range: got %h expected below 00000040", bus.address);
            end
            wr_count++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (bus.write && bus.waitrequest) begin
            chk("stall_st_ready", 32'(bus.st_ready), 32'd0);
            chk("stall_address", bus.address, stall_addr);
            chk("stall_writedata", bus.writedata, stall_data);
        end
    end

    task automatic send_beat(logic [31:0] d, logic sop, logic eop, logic [1:0] emp);
        int n;
        bus.st_valid = 1'b1;
        bus.st_data  = d;
        bus.st_sop   = sop;
        bus.st_eop   = eop;
        bus.st_empty = eop ? emp : 2'd0;
        n = 0;
        while (!bus.st_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("st_ready_wait", 32'(bus.st_ready), 32'd1);
        @(negedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.st_sop   = 1'b0;
        bus.st_eop   = 1'b0;
    endtask

    task automatic begin_frame(int v);
        cur_v = v;
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
        wr_count   = 0;
        first_cyc  = -1;
        last_cyc   = -1;
        stall_left = 0;
        stall_addr = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rd();
        int n;
        n = 0;
        while (!bus.rd_ctrl && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rd_ctrl_up", 32'(bus.rd_ctrl), 32'd1);
    endtask

    task automatic release_reader();
        bus.rd_ctrl_rdy = 1'b1;
        @(negedge clk);
        #1;
        bus.rd_ctrl_rdy = 1'b0;
        chk("rd_ctrl_drop", 32'(bus.rd_ctrl), 32'd0);
        chk("idle_st_ready", 32'(bus.st_ready), 32'd1);
    endtask

    task automatic check_mem(int v, int nw);
        for (int i = 0; i < nw; i++) chk($sformatf("mem[%0d]", i), mem[i], fdata(v, i));
        chk("mem_beyond", mem[nw], 32'hDEAD_BEEF);
    endtask

    task automatic run_frame(vec_t t);
        begin_frame(t.v);
        if (t.stall_n > 0) begin
            stall_addr = 32'(t.stall_idx) * 4;
            stall_data = fdata(t.v, t.stall_idx);
            stall_left = t.stall_n;
        end
        for (int i = 0; i < t.n; i++) send_beat(fdata(t.v, i), i == 0, i == t.n - 1, t.emp);
        wait_rd();
        chk("wr_count", 32'(wr_count), 32'(t.exp_wr));
        chk("wr_span", 32'(last_cyc - first_cyc), 32'(t.exp_span));
        chk("pkt_begin", bus.pkt_begin, 32'd0);
        chk("pkt_end", bus.pkt_end, t.exp_end);
        chk("control", bus.control, t.exp_ctrl);
        check_mem(t.v, t.exp_wr);
        repeat (3) @(negedge clk);
        #1;
        chk("rd_ctrl_held", 32'(bus.rd_ctrl), 32'd1);
        release_reader();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        //         v  n  emp sidx sn  end    ctrl          wr span
        vecs[0] = '{0, 8, 2'd0, 0, 0, 32'd32, 32'd32,        8, 7};
        vecs[1] = '{1, 3, 2'd3, 0, 0, 32'd12, 32'd9,         3, 2};
        vecs[2] = '{2, 8, 2'd0, 1, 3, 32'd32, 32'd32,        8, 10};
        vecs[3] = '{3, 12, 2'd0, 0, 0, 32'd32, 32'h0001_0020, 8, 7};
        vecs[4] = '{4, 1, 2'd2, 0, 0, 32'd4,  32'd2,         1, 0};
        vecs[5] = '{5, 8, 2'd1, 0, 0, 32'd32, 32'd31,        8, 7};
        vecs[6] = '{6, 9, 2'd2, 0, 0, 32'd32, 32'h0001_0020, 8, 7};

        reset           = 1'b0;
        bus.st_valid    = 1'b0;
        bus.st_data     = 32'd0;
        bus.st_sop      = 1'b0;
        bus.st_eop      = 1'b0;
        bus.st_empty    = 2'd0;
        bus.rd_ctrl_rdy = 1'b0;
        begin_frame(0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_st_ready", 32'(bus.st_ready), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_address", bus.address, 32'd0);
        chk("rst_writedata", bus.writedata, 32'd0);
        chk("rst_rd_ctrl", 32'(bus.rd_ctrl), 32'd0);
        chk("rst_pkt_end", bus.pkt_end, 32'd0);
        chk("rst_control", bus.control, 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Back-to-back frames: the second frame arrives during HANDOFF and is dropped.
        begin_frame(20);
        for (int i = 0; i < 4; i++) send_beat(fdata(20, i), i == 0, i == 3, 2'd0);
        for (int i = 0; i < 3; i++) send_beat(fdata(21, i), i == 0, i == 2, 2'd0);
        wait_rd();
        repeat (50) @(negedge clk);
        #1;
        chk("b2b_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("b2b_wr_count", 32'(wr_count), 32'd4);
        chk("b2b_pkt_begin", bus.pkt_begin, 32'd0);
        chk("b2b_pkt_end", bus.pkt_end, 32'd16);
        chk("b2b_control", bus.control, 32'd16);
        chk("b2b_rd_ctrl", 32'(bus.rd_ctrl), 32'd1);
        check_mem(20, 4);
        release_reader();

        // A sop arrives before eop: the current frame closes with the error flag set.
        begin_frame(22);
        for (int i = 0; i < 3; i++) send_beat(fdata(22, i), i == 0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) send_beat(fdata(23, i), i == 0, i == 2, 2'd1);
        wait_rd();
        chk("noeop_drop_cnt", 32'(bus.drop_cnt), 32'd2);
        chk("noeop_wr_count", 32'(wr_count), 32'd3);
        chk("noeop_pkt_end", bus.pkt_end, 32'd12);
        chk("noeop_control", bus.control, 32'h0002_000C);
        check_mem(22, 3);
        release_reader();
        repeat (2) @(negedge clk);
        #1;
        chk("noeop_no_capture", 32'(wr_count), 32'd3);

        // Reset arrives in the middle of CAPTURE.
        begin_frame(24);
        for (int i = 0; i < 3; i++) send_beat(fdata(24, i), i == 0, 1'b0, 2'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_write", 32'(bus.write), 32'd0);
        chk("mid_rst_rd_ctrl", 32'(bus.rd_ctrl), 32'd0);
        chk("mid_rst_st_ready", 32'(bus.st_ready), 32'd0);
        chk("mid_rst_address", bus.address, 32'd0);
        chk("mid_rst_control", bus.control, 32'd0);
        chk("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        run_frame('{25, 2, 2'd0, 0, 0, 32'd8, 32'd8, 2, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
